// File: rtl/vga_frame_dbuf_if.sv
// vga_frame_dbuf_if: CPU write, swap control and display read signals of the double-buffered frame store
// master: drives write/swap/read requests; slave: the frame store answering them
interface vga_frame_dbuf_if #(
  parameter int X_W = 8,
  parameter int Y_W = 8,
  parameter int CHANNELS = 3,
  parameter int CH_W = 4
);
  logic i_wr_en;
  logic [X_W-1:0] i_wr_x;
  logic [Y_W-1:0] i_wr_y;
  logic [CHANNELS-1:0] i_wr_chmask;
  logic [CHANNELS*CH_W-1:0] i_wr_data;
  logic o_wr_ready;
  logic o_wr_err;
  logic i_swap_req;
  logic i_clear_en;
  logic i_vsync;
  logic o_swap_pending;
  logic o_swap_done;
  logic o_front;
  logic i_rd_en;
  logic [X_W-1:0] i_pxl_x;
  logic [Y_W-1:0] i_pxl_y;
  logic [CHANNELS*CH_W-1:0] o_color;
  logic o_color_valid;
  modport master (
    output i_wr_en, i_wr_x, i_wr_y, i_wr_chmask, i_wr_data, i_swap_req, i_clear_en, i_vsync,
           i_rd_en, i_pxl_x, i_pxl_y,
    input  o_wr_ready, o_wr_err, o_swap_pending, o_swap_done, o_front, o_color, o_color_valid
  );
  modport slave (
    input  i_wr_en, i_wr_x, i_wr_y, i_wr_chmask, i_wr_data, i_swap_req, i_clear_en, i_vsync,
           i_rd_en, i_pxl_x, i_pxl_y,
    output o_wr_ready, o_wr_err, o_swap_pending, o_swap_done, o_front, o_color, o_color_valid
  );
endinterface

// File: rtl/vga_frame_dbuf.sv
// vga_frame_dbuf: double-buffered VGA frame store with vsync-deferred swap and optional back-bank clear
// i_clk, i_rst_n (sync, active low); bus: masked CPU writes to back bank, swap control, 1-cycle front-bank reads
module vga_frame_dbuf #(
  parameter int H_RES = 160,
  parameter int V_RES = 120,
  parameter int X_W = 8,
  parameter int Y_W = 8,
  parameter int CHANNELS = 3,
  parameter int CH_W = 4,
  parameter logic [CH_W-1:0] CLEAR_VAL = '0
) (
  input logic i_clk,
  input logic i_rst_n,
  vga_frame_dbuf_if.slave bus
);
  localparam int N = H_RES * V_RES;
  localparam int AW = $clog2(2 * N);
  localparam int DW = CHANNELS * CH_W;
  typedef enum logic [1:0] {IDLE, PENDING, CLEAR} state_t;
  state_t state, state_n;
  logic front, front_n, clr_flag, clr_n, swap, wr_we, clr_we, wr_oob, rd_oob;
  logic wr_err, swap_done, color_valid;
  logic [DW-1:0] color;
  logic [AW-1:0] cnt, cnt_n, wr_lin, rd_lin, wr_addr, rd_addr, clr_addr;
  logic [CHANNELS-1:0][CH_W-1:0] mem [2*N];
  // banks live at offsets 0 and N; range is checked on coordinates so nothing aliases
  assign wr_lin = AW'(bus.i_wr_y) * AW'(H_RES) + AW'(bus.i_wr_x);
  assign rd_lin = AW'(bus.i_pxl_y) * AW'(H_RES) + AW'(bus.i_pxl_x);
  assign wr_oob = int'(bus.i_wr_x) >= H_RES || int'(bus.i_wr_y) >= V_RES;
  assign rd_oob = int'(bus.i_pxl_x) >= H_RES || int'(bus.i_pxl_y) >= V_RES;
  assign wr_addr = front ? wr_lin : wr_lin + AW'(N);
  assign clr_addr = front ? cnt : cnt + AW'(N);
  assign rd_addr = front ? rd_lin + AW'(N) : rd_lin;
  assign wr_we = bus.i_wr_en && state != CLEAR && !wr_oob;
  assign clr_we = state == CLEAR;
  assign bus.o_wr_ready = state != CLEAR;
  assign bus.o_swap_pending = state == PENDING;
  assign bus.o_swap_done = swap_done;
  assign bus.o_wr_err = wr_err;
  assign bus.o_front = front;
  assign bus.o_color = color;
  assign bus.o_color_valid = color_valid;
  always_comb begin
    swap = state == PENDING && bus.i_vsync;
    front_n = front ^ swap;
    clr_n = state == IDLE && bus.i_swap_req ? bus.i_clear_en : clr_flag;
    cnt_n = state == CLEAR ? cnt + AW'(1) : '0;
    state_n = state == IDLE ? (bus.i_swap_req ? PENDING : IDLE) :
              state == PENDING ? (bus.i_vsync ? (clr_flag ? CLEAR : IDLE) : PENDING) :
              cnt == AW'(N - 1) ? IDLE : CLEAR;
  end
  always_ff @(posedge i_clk) begin
    if (!i_rst_n) begin
      state <= IDLE;
      front <= 1'b0;
      clr_flag <= 1'b0;
      cnt <= '0;
      wr_err <= 1'b0;
      swap_done <= 1'b0;
      color <= '0;
      color_valid <= 1'b0;
    end else begin
      state <= state_n;
      front <= front_n;
      clr_flag <= clr_n;
      cnt <= cnt_n;
      wr_err <= bus.i_wr_en && state != CLEAR && wr_oob;
      swap_done <= swap;
      color_valid <= bus.i_rd_en;
      if (bus.i_rd_en) color <= rd_oob ? '0 : mem[rd_addr];
    end
  end
  // memory is never reset; gating on i_rst_n makes reset abort an in-progress clear
  always_ff @(posedge i_clk) begin
    if (i_rst_n && clr_we) mem[clr_addr] <= {CHANNELS{CLEAR_VAL}};
    else if (i_rst_n && wr_we)
      for (int c = 0; c < CHANNELS; c++)
        if (bus.i_wr_chmask[c]) mem[wr_addr][c] <= bus.i_wr_data[c*CH_W +: CH_W];
  end
endmodule

// File: tb/tb_vga_frame_dbuf.sv
// tb_vga_frame_dbuf: scoreboard bench for vga_frame_dbuf with a behavioural frame-store model
module tb_vga_frame_dbuf;
  localparam int H = 160, V = 120, N = H * V, XW = 8, YW = 8, C = 3, CW = 4, DW = C * CW;
  localparam logic [CW-1:0] CLR = '0;
  typedef struct {logic [DW-1:0] d; bit k;} exp_t;
  logic clk = 0, rst_n = 0;
  always #5 clk = ~clk;
  vga_frame_dbuf_if #(.X_W(XW), .Y_W(YW), .CHANNELS(C), .CH_W(CW)) bus();
  vga_frame_dbuf #(.H_RES(H), .V_RES(V), .X_W(XW), .Y_W(YW), .CHANNELS(C), .CH_W(CW), .CLEAR_VAL(CLR))
    dut (.i_clk(clk), .i_rst_n(rst_n), .bus(bus));
  logic [DW-1:0] ref_mem [2][N];
  bit kn [2][N];
  bit m_front, m_pend, m_clr, e_done, e_err, e_valid, on;
  int m_clr_left, n_chk, n_fail;
  exp_t sb[$];
  task automatic chk(string nm, logic [DW-1:0] act, logic [DW-1:0] exp);
    n_chk++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h expected %0h at %0t", nm, act, exp, $time);
    end
  endtask
  task automatic model();
    int lin;
    bit acc, oob;
    exp_t e;
    if (!rst_n) begin
      m_front = 0; m_pend = 0; m_clr = 0; m_clr_left = 0; e_done = 0; e_err = 0; e_valid = 0;
      return;
    end
    if (bus.i_rd_en) begin
      if (bus.i_pxl_x < H && bus.i_pxl_y < V) begin
        lin = bus.i_pxl_y * H + bus.i_pxl_x;
        e.d = ref_mem[m_front][lin];
        e.k = kn[m_front][lin];
      end else begin
        e.d = '0;
        e.k = 1;
      end
      sb.push_back(e);
    end
    e_valid = bus.i_rd_en;
    acc = bus.i_wr_en && m_clr_left == 0;
    oob = bus.i_wr_x >= H || bus.i_wr_y >= V;
    e_err = acc && oob;
    if (acc && !oob) begin
      lin = bus.i_wr_y * H + bus.i_wr_x;
      for (int c = 0; c < C; c++)
        if (bus.i_wr_chmask[c]) ref_mem[!m_front][lin][c*CW +: CW] = bus.i_wr_data[c*CW +: CW];
      kn[!m_front][lin] = kn[!m_front][lin] || &bus.i_wr_chmask;
    end
    e_done = 0;
    if (m_clr_left > 0) begin
      ref_mem[!m_front][N - m_clr_left] = {C{CLR}};
      kn[!m_front][N - m_clr_left] = 1;
      m_clr_left--;
    end else if (m_pend) begin
      if (bus.i_vsync) begin
        m_front = !m_front; e_done = 1; m_pend = 0;
        if (m_clr) m_clr_left = N;
      end
    end else if (bus.i_swap_req) begin
      m_pend = 1;
      m_clr = bus.i_clear_en;
    end
  endtask
  task automatic step();
    @(posedge clk);
    model();
    #1;
  endtask
  task automatic wr(int x, int y, logic [C-1:0] m, logic [DW-1:0] d);
    bus.i_wr_en = 1; bus.i_wr_x = XW'(x); bus.i_wr_y = YW'(y); bus.i_wr_chmask = m; bus.i_wr_data = d;
    step();
    bus.i_wr_en = 0;
  endtask
  task automatic rd(int x, int y);
    bus.i_rd_en = 1; bus.i_pxl_x = XW'(x); bus.i_pxl_y = YW'(y);
    step();
    bus.i_rd_en = 0;
  endtask
  task automatic swap(bit clr, int gap);
    bus.i_swap_req = 1; bus.i_clear_en = clr;
    step();
    bus.i_swap_req = 0; bus.i_clear_en = 0;
    repeat (gap) step();
    bus.i_vsync = 1;
    step();
    bus.i_vsync = 0;
  endtask
  always @(negedge clk) begin
    if (on) begin
      chk("wr_ready", DW'(bus.o_wr_ready), DW'(m_clr_left == 0));
      chk("swap_pending", DW'(bus.o_swap_pending), DW'(m_pend));
      chk("front", DW'(bus.o_front), DW'(m_front));
      chk("swap_done", DW'(bus.o_swap_done), DW'(e_done));
      chk("wr_err", DW'(bus.o_wr_err), DW'(e_err));
      chk("color_valid", DW'(bus.o_color_valid), DW'(e_valid));
      if (bus.o_color_valid) begin
        if (sb.size() == 0) begin
          n_chk++; n_fail++;
          $display("FAIL color_unexpected: valid with empty scoreboard at %0t", $time);
        end else begin
          exp_t e;
          e = sb.pop_front();
          if (e.k) chk("color", bus.o_color, e.d);
        end
      end
    end
  end
  initial begin
    int cnt;
    bus.i_wr_en = 0; bus.i_wr_x = 0; bus.i_wr_y = 0; bus.i_wr_chmask = 0; bus.i_wr_data = 0;
    bus.i_swap_req = 0; bus.i_clear_en = 0; bus.i_vsync = 0; bus.i_rd_en = 0; bus.i_pxl_x = 0; bus.i_pxl_y = 0;
    step();
    on = 1;
    step();
    chk("rst_color", bus.o_color, '0);
    chk("rst_valid", DW'(bus.o_color_valid), '0);
    chk("rst_ready", DW'(bus.o_wr_ready), DW'(1'b1));
    rst_n = 1;
    wr(5, 3, 3'b111, 12'hABC);
    swap(0, 2);
    rd(5, 3);
    chk("t1_color", bus.o_color, 12'hABC);
    chk("t1_front", DW'(bus.o_front), DW'(1'b1));
    wr(5, 3, 3'b111, 12'hABC);
    wr(5, 3, 3'b010, 12'h0F0);
    swap(0, 1);
    rd(5, 3);
    chk("t2_masked", bus.o_color, 12'hAFC);
    bus.i_swap_req = 1; bus.i_clear_en = 1;
    step();
    bus.i_swap_req = 0; bus.i_clear_en = 0;
    cnt = 0;
    for (int i = 0; i < 10; i++) begin
      if (bus.o_swap_pending) cnt++;
      step();
    end
    chk("t3_pending_cycles", DW'(cnt), DW'(10));
    bus.i_vsync = 1;
    step();
    bus.i_vsync = 0;
    chk("t3_swap_done", DW'(bus.o_swap_done), DW'(1'b1));
    cnt = 0;
    for (int i = 0; i < N + 10; i++) begin
      if (!bus.o_wr_ready) cnt++;
      step();
    end
    chk("t3_clear_cycles", DW'(cnt), DW'(N));
    swap(0, 0);
    for (int y = 0; y < V; y++)
      for (int x = 0; x < H; x++) begin
        rd(x, y);
        if (x == y || x == H - 1) chk("t3_cleared", bus.o_color, {C{CLR}});
      end
    wr(0, 1, 3'b111, 12'h123);
    wr(160, 0, 3'b111, 12'hFFF);
    chk("t4_wr_err", DW'(bus.o_wr_err), DW'(1'b1));
    wr(0, 120, 3'b111, 12'hEEE);
    swap(0, 0);
    rd(0, 1);
    chk("t4_no_alias", bus.o_color, 12'h123);
    rd(0, 120);
    chk("t4_oob_color", bus.o_color, '0);
    chk("t4_oob_valid", DW'(bus.o_color_valid), DW'(1'b1));
    bus.i_swap_req = 1; bus.i_vsync = 1;
    step();
    bus.i_swap_req = 0; bus.i_vsync = 0;
    chk("t5_no_same_cycle", DW'(bus.o_front), DW'(1'b1));
    step();
    bus.i_swap_req = 1;
    step();
    bus.i_swap_req = 0;
    bus.i_vsync = 1;
    step();
    bus.i_vsync = 0;
    chk("t5_toggle", DW'(bus.o_front), '0);
    repeat (3) step();
    bus.i_vsync = 1;
    step();
    bus.i_vsync = 0;
    chk("t5_single_toggle", DW'(bus.o_front), '0);
    swap(0, 0);
    wr(159, 119, 3'b111, 12'h5A5);
    swap(0, 0);
    swap(1, 0);
    repeat (5000) step();
    rst_n = 0;
    step();
    rst_n = 1;
    chk("t6_ready", DW'(bus.o_wr_ready), DW'(1'b1));
    chk("t6_front", DW'(bus.o_front), '0);
    rd(159, 119);
    chk("t6_uncleared", bus.o_color, 12'h5A5);
    rd(0, 0);
    chk("t6_cleared", bus.o_color, {C{CLR}});
    for (int i = 0; i < 3000; i++) begin
      bus.i_wr_en = $urandom_range(0, 1);
      bus.i_wr_x = XW'($urandom_range(0, 170)); bus.i_wr_y = YW'($urandom_range(0, 130));
      bus.i_wr_chmask = C'($urandom); bus.i_wr_data = DW'($urandom);
      bus.i_rd_en = $urandom_range(0, 1);
      bus.i_pxl_x = XW'($urandom_range(0, 170)); bus.i_pxl_y = YW'($urandom_range(0, 130));
      bus.i_swap_req = $urandom_range(0, 15) == 0;
      bus.i_vsync = $urandom_range(0, 30) == 0;
      step();
    end
    bus.i_wr_en = 0; bus.i_rd_en = 0; bus.i_swap_req = 0; bus.i_vsync = 0;
    repeat (3) step();
    chk("sb_drained", DW'(sb.size()), '0);
    on = 0;
    $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
    $finish;
  end
endmodule
